// File: rtl/tc_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tc_timer_pkg : shared state and mode encodings for tc_timer    |
// | Revision     : 1.0                                             |
// +----------------------------------------------------------------+
package tc_timer_pkg;

  typedef enum logic [0:0] {
    TC_IDLE = 1'b0,
    TC_RUN  = 1'b1
  } tc_state_e;

  localparam logic TC_ONESHOT  = 1'b0;
  localparam logic TC_PERIODIC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tc_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tc_timer_if : control/status bundle between host and tc_timer  |
// | Revision    : 1.0                                              |
// +----------------------------------------------------------------+
interface tc_timer_if #(
  parameter int WIDTH = 8
);
  logic             tick_in;
  logic             start_in;
  logic             stop_in;
  logic             mode_in;
  logic [WIDTH-1:0] load_in;
  logic             ack_in;
  logic             busy_out;
  logic             expire_out;
  logic             irq_out;
  logic             ovf_out;
  logic [WIDTH-1:0] count_out;

  modport master (
    output tick_in, start_in, stop_in, mode_in, load_in, ack_in,
    input  busy_out, expire_out, irq_out, ovf_out, count_out
  );

  modport slave (
    input  tick_in, start_in, stop_in, mode_in, load_in, ack_in,
    output busy_out, expire_out, irq_out, ovf_out, count_out
  );
endinterface
`default_nettype wire

// File: rtl/tc_timer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tc_timer : programmable one-shot/periodic down-counting timer  |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  tc_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  tc_state_e        r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_expire;
  logic             r_irq;
  logic             r_ovf;

  logic             w_start_ok;
  logic             w_expiry;

  assign w_start_ok = bus.start_in && (bus.load_in != '0);
  // Final tick only counts when neither stop nor a valid restart outranks it
  assign w_expiry   = (r_state == TC_RUN) && !bus.stop_in && !w_start_ok &&
                      bus.tick_in && (r_count == c_one);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= TC_IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_mode   <= TC_ONESHOT;
      r_expire <= 1'b0;
      r_irq    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_expire <= w_expiry;
      case (r_state)
        TC_IDLE: begin
          if (w_start_ok) begin
            r_count  <= bus.load_in;
            r_period <= bus.load_in;
            r_mode   <= bus.mode_in;
            r_ovf    <= 1'b0;
            r_state  <= TC_RUN;
          end
        end
        TC_RUN: begin
          if (bus.stop_in) begin
            r_state <= TC_IDLE;
          end else if (w_start_ok) begin
            r_count  <= bus.load_in;
            r_period <= bus.load_in;
            r_mode   <= bus.mode_in;
          end else if (bus.tick_in) begin
            if (r_count > c_one) begin
              r_count <= r_count - c_one;
            end else if (r_count == c_one) begin
              if (r_mode == TC_PERIODIC) begin
                r_count <= r_period;
              end else begin
                r_count <= '0;
                r_state <= TC_IDLE;
              end
            end
          end
        end
        default: r_state <= TC_IDLE;
      endcase
      // A fresh expiry beats a coincident acknowledge
      if (w_expiry) begin
        r_irq <= 1'b1;
        if (r_irq && !bus.ack_in) r_ovf <= 1'b1;
      end else if (bus.ack_in) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign bus.busy_out   = (r_state == TC_RUN);
  assign bus.expire_out = r_expire;
  assign bus.irq_out    = r_irq;
  assign bus.ovf_out    = r_ovf;
  assign bus.count_out  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_tc_timer : directed + randomized checks of tc_timer         |
// | Revision    : 1.0                                              |
// +----------------------------------------------------------------+
module tb_tc_timer;

  logic       tb_clk_in = 1'b0;
  logic       tb_rst_in = 1'b1;
  logic       use_fr    = 1'b0;
  logic       man_tick  = 1'b0;
  logic [3:0] fr_cnt;
  logic       fr_tc;
  int         n_checks  = 0;
  int         n_pass    = 0;

  // Reference model state
  bit m_run, m_periodic, m_irq, m_ovf, m_exp;
  int m_left, m_period;

  always #5 tb_clk_in = ~tb_clk_in;

  tc_timer_if #(.WIDTH(8)) bus ();

  tc_timer #(.WIDTH(8)) dut (
    .clk_in (tb_clk_in),
    .rst_in (tb_rst_in),
    .bus    (bus.slave)
  );

  // Free-running 4-bit timebase: terminal count every 16 clocks
  always @(posedge tb_clk_in or posedge tb_rst_in) begin
    if (tb_rst_in) fr_cnt <= 4'd0;
    else           fr_cnt <= fr_cnt + 4'd1;
  end
  assign fr_tc       = (fr_cnt == 4'hF);
  assign bus.tick_in = use_fr ? fr_tc : man_tick;

  always @(posedge tb_clk_in or posedge tb_rst_in) begin
    bit l_run, l_periodic, l_irq, l_ovf, fired, start_ok;
    int l_left, l_period;
    if (tb_rst_in) begin
      m_run <= 0; m_periodic <= 0; m_irq <= 0; m_ovf <= 0; m_exp <= 0;
      m_left <= 0; m_period <= 0;
    end else begin
      l_run = m_run; l_periodic = m_periodic; l_irq = m_irq; l_ovf = m_ovf;
      l_left = m_left; l_period = m_period; fired = 0;
      start_ok = bus.start_in && (bus.load_in != 0);
      if (!l_run) begin
        if (start_ok) begin
          l_run = 1; l_left = int'(bus.load_in); l_period = l_left;
          l_periodic = bus.mode_in; l_ovf = 0;
        end
      end else if (bus.stop_in) begin
        l_run = 0;
      end else if (start_ok) begin
        l_left = int'(bus.load_in); l_period = l_left; l_periodic = bus.mode_in;
      end else if (bus.tick_in) begin
        l_left = l_left - 1;
        if (l_left == 0) begin
          fired = 1;
          if (l_periodic) l_left = l_period;
          else            l_run = 0;
        end
      end
      if (fired) begin
        if (l_irq && !bus.ack_in) l_ovf = 1;
        l_irq = 1;
      end else if (bus.ack_in) begin
        l_irq = 0;
      end
      m_run <= l_run; m_periodic <= l_periodic; m_irq <= l_irq; m_ovf <= l_ovf;
      m_left <= l_left; m_period <= l_period; m_exp <= fired;
    end
  end

  task automatic drive(input bit s, input bit p, input bit t, input bit a);
    bus.start_in = s; bus.stop_in = p; man_tick = t; bus.ack_in = a;
    @(posedge tb_clk_in);
    @(negedge tb_clk_in);
    bus.start_in = 0; bus.stop_in = 0; man_tick = 0; bus.ack_in = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge tb_clk_in);
    tb_rst_in = 0;
    @(negedge tb_clk_in);
    n_checks++; if (bus.busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_out); else n_pass++;
    n_checks++; if (bus.expire_out !== 1'b0) $display("FAIL reset_expire: got %b want 0", bus.expire_out); else n_pass++;
    n_checks++; if (bus.irq_out !== 1'b0) $display("FAIL reset_irq: got %b want 0", bus.irq_out); else n_pass++;
    n_checks++; if (bus.ovf_out !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf_out); else n_pass++;
    n_checks++; if (bus.count_out !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.count_out); else n_pass++;
  endtask

  task automatic test_oneshot();
    int seq[$];
    bit seen = 0;
    use_fr = 1;
    bus.load_in = 8'd3; bus.mode_in = 1'b0;
    drive(1, 0, 0, 0);
    seq.push_back(int'(bus.count_out));
    n_checks++; if (bus.busy_out !== 1'b1) $display("FAIL oneshot_busy_start: got %b want 1", bus.busy_out); else n_pass++;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge tb_clk_in); @(negedge tb_clk_in);
      if (int'(bus.count_out) != seq[$]) seq.push_back(int'(bus.count_out));
      if (bus.expire_out) seen = 1;
    end
    n_checks++; if (!seen) $display("FAIL oneshot_expire: got no pulse want pulse within 80 cycles"); else n_pass++;
    n_checks++; if (bus.busy_out !== 1'b0) $display("FAIL oneshot_busy_fall: got %b want 0", bus.busy_out); else n_pass++;
    n_checks++; if (bus.irq_out !== 1'b1) $display("FAIL oneshot_irq: got %b want 1", bus.irq_out); else n_pass++;
    n_checks++;
    if (seq.size() != 4 || seq[0] != 3 || seq[1] != 2 || seq[2] != 1 || seq[3] != 0)
      $display("FAIL oneshot_sequence: got %p want '{3,2,1,0}", seq);
    else n_pass++;
    @(posedge tb_clk_in); @(negedge tb_clk_in);
    n_checks++; if (bus.expire_out !== 1'b0) $display("FAIL oneshot_pulse_width: got %b want 0", bus.expire_out); else n_pass++;
    use_fr = 0;
  endtask

  task automatic test_periodic();
    int ticks = 0, nexp = 0;
    use_fr = 1;
    drive(0, 0, 0, 1);
    bus.load_in = 8'd2; bus.mode_in = 1'b1;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 150 && nexp < 3; i++) begin
      if (bus.tick_in) ticks++;
      @(posedge tb_clk_in); @(negedge tb_clk_in);
      if (bus.expire_out) begin
        nexp++;
        n_checks++; if (ticks != 2 * nexp) $display("FAIL periodic_tick_count: got %0d want %0d", ticks, 2 * nexp); else n_pass++;
        n_checks++; if (bus.count_out !== 8'd2) $display("FAIL periodic_reload: got %0d want 2", bus.count_out); else n_pass++;
        n_checks++; if (bus.busy_out !== 1'b1) $display("FAIL periodic_busy: got %b want 1", bus.busy_out); else n_pass++;
        n_checks++; if (bus.ovf_out !== (nexp >= 2)) $display("FAIL periodic_ovf: got %b want %b", bus.ovf_out, nexp >= 2); else n_pass++;
      end
    end
    n_checks++; if (nexp != 3) $display("FAIL periodic_expiries: got %0d want 3", nexp); else n_pass++;
    use_fr = 0;
    drive(0, 1, 0, 0);
  endtask

  task automatic test_stop_priority();
    bus.load_in = 8'd7; bus.mode_in = 1'b1;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    n_checks++; if (bus.count_out !== 8'd5) $display("FAIL stop_setup_count: got %0d want 5", bus.count_out); else n_pass++;
    bus.load_in = 8'd9;
    drive(1, 1, 1, 0);
    n_checks++; if (bus.busy_out !== 1'b0) $display("FAIL stop_busy: got %b want 0", bus.busy_out); else n_pass++;
    n_checks++; if (bus.count_out !== 8'd5) $display("FAIL stop_count_hold: got %0d want 5", bus.count_out); else n_pass++;
    n_checks++; if (bus.expire_out !== 1'b0) $display("FAIL stop_no_expire: got %b want 0", bus.expire_out); else n_pass++;
  endtask

  task automatic test_restart();
    bus.load_in = 8'd6; bus.mode_in = 1'b0;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    n_checks++; if (bus.count_out !== 8'd4) $display("FAIL restart_setup_count: got %0d want 4", bus.count_out); else n_pass++;
    bus.load_in = 8'd9; bus.mode_in = 1'b1;
    drive(1, 0, 1, 0);
    n_checks++; if (bus.count_out !== 8'd9) $display("FAIL restart_count: got %0d want 9", bus.count_out); else n_pass++;
    repeat (9) drive(0, 0, 1, 0);
    n_checks++; if (bus.expire_out !== 1'b1) $display("FAIL restart_expire: got %b want 1", bus.expire_out); else n_pass++;
    n_checks++; if (bus.busy_out !== 1'b1) $display("FAIL restart_mode_periodic: got %b want 1", bus.busy_out); else n_pass++;
    n_checks++; if (bus.count_out !== 8'd9) $display("FAIL restart_reload: got %0d want 9", bus.count_out); else n_pass++;
    drive(0, 1, 0, 0);
  endtask

  task automatic test_zero_ack();
    int held;
    drive(0, 0, 0, 1);
    held = m_left;
    bus.load_in = 8'd0; bus.mode_in = 1'b1;
    drive(1, 0, 0, 0);
    n_checks++; if (bus.busy_out !== 1'b0) $display("FAIL zero_load_busy: got %b want 0", bus.busy_out); else n_pass++;
    n_checks++; if (int'(bus.count_out) != held) $display("FAIL zero_load_count: got %0d want %0d", bus.count_out, held); else n_pass++;
    bus.load_in = 8'd1;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    n_checks++; if (bus.expire_out !== 1'b1) $display("FAIL ack_first_expire: got %b want 1", bus.expire_out); else n_pass++;
    n_checks++; if (bus.irq_out !== 1'b1) $display("FAIL ack_first_irq: got %b want 1", bus.irq_out); else n_pass++;
    drive(0, 0, 1, 1);
    n_checks++; if (bus.irq_out !== 1'b1) $display("FAIL ack_race_irq: got %b want 1", bus.irq_out); else n_pass++;
    n_checks++; if (bus.ovf_out !== 1'b0) $display("FAIL ack_race_ovf: got %b want 0", bus.ovf_out); else n_pass++;
    drive(0, 0, 0, 1);
    n_checks++; if (bus.irq_out !== 1'b0) $display("FAIL ack_clear_irq: got %b want 0", bus.irq_out); else n_pass++;
    drive(0, 1, 0, 0);
  endtask

  task automatic test_reset_midrun();
    bus.load_in = 8'd200; bus.mode_in = 1'b1;
    drive(1, 0, 0, 0);
    repeat (50) drive(0, 0, 1, 0);
    n_checks++; if (bus.count_out !== 8'd150) $display("FAIL midrun_count: got %0d want 150", bus.count_out); else n_pass++;
    @(posedge tb_clk_in);
    #2 tb_rst_in = 1;
    #1;
    n_checks++; if (bus.busy_out !== 1'b0) $display("FAIL async_busy: got %b want 0", bus.busy_out); else n_pass++;
    n_checks++; if (bus.count_out !== 8'd0) $display("FAIL async_count: got %0d want 0", bus.count_out); else n_pass++;
    n_checks++; if (bus.irq_out !== 1'b0 || bus.ovf_out !== 1'b0 || bus.expire_out !== 1'b0)
      $display("FAIL async_flags: got irq=%b ovf=%b exp=%b want all 0", bus.irq_out, bus.ovf_out, bus.expire_out);
    else n_pass++;
    @(negedge tb_clk_in);
    tb_rst_in = 0;
    repeat (4) drive(0, 0, 1, 0);
    n_checks++; if (bus.busy_out !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", bus.busy_out); else n_pass++;
    n_checks++; if (bus.count_out !== 8'd0) $display("FAIL post_reset_count: got %0d want 0", bus.count_out); else n_pass++;
  endtask

  task automatic test_random();
    bit s, p, t, a;
    for (int i = 0; i < 400; i++) begin
      use_fr      = ($urandom_range(0, 3) == 0);
      bus.load_in = 8'($urandom_range(0, 4));
      bus.mode_in = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 5) == 0);
      drive(s, p, t, a);
      n_checks++; if (bus.busy_out !== m_run) $display("FAIL rand_busy[%0d]: got %b want %b", i, bus.busy_out, m_run); else n_pass++;
      n_checks++; if (bus.expire_out !== m_exp) $display("FAIL rand_expire[%0d]: got %b want %b", i, bus.expire_out, m_exp); else n_pass++;
      n_checks++; if (bus.irq_out !== m_irq) $display("FAIL rand_irq[%0d]: got %b want %b", i, bus.irq_out, m_irq); else n_pass++;
      n_checks++; if (bus.ovf_out !== m_ovf) $display("FAIL rand_ovf[%0d]: got %b want %b", i, bus.ovf_out, m_ovf); else n_pass++;
      n_checks++; if (int'(bus.count_out) != m_left) $display("FAIL rand_count[%0d]: got %0d want %0d", i, bus.count_out, m_left); else n_pass++;
    end
    use_fr = 0;
  endtask

  initial begin
    bus.start_in = 0; bus.stop_in = 0; bus.ack_in = 0;
    bus.mode_in = 0; bus.load_in = 8'd0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop_priority();
    test_restart();
    test_zero_ack();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
